// File: rtl/t_chg_sequencer.sv
// Test-harness sequencer: divides clk into test_clk, counts test_clk rising edges and
// collects sticky pass flags, reporting pass or timeout.
module t_chg_sequencer #(
  parameter int unsigned N_TESTS = 4,
  parameter int unsigned DIV     = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CW      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_TESTS-1:0] passed_in,
  output logic               test_clk,
  output logic               test_run,
  output logic               done,
  output logic               all_passed,
  output logic               timed_out,
  output logic [N_TESTS-1:0] seen,
  output logic [CW-1:0]      edge_count
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tclk_q, tclk_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               to_q, to_d;
  logic [N_TESTS-1:0] seen_q, seen_d;
  logic [CW-1:0]      edge_q, edge_d;

  logic [N_TESTS-1:0] seen_nxt;
  logic               div_wrap;
  logic               rise;
  logic [CW-1:0]      edge_inc;

  always_comb begin
    seen_nxt = seen_q | passed_in;
    div_wrap = (div_q == DW'(DIV - 1));
    rise     = div_wrap && !tclk_q;
    edge_inc = (edge_q == {CW{1'b1}}) ? edge_q : edge_q + 1'b1;

    state_d = state_q;
    div_d   = div_q;
    tclk_d  = tclk_q;
    done_d  = done_q;
    pass_d  = pass_q;
    to_d    = to_q;
    seen_d  = seen_q;
    edge_d  = edge_q;

    unique case (state_q)
      StIdle, StPass, StFail: begin
        tclk_d = 1'b0;
        if (start) begin
          state_d = StRun;
          div_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          seen_d  = '0;
          edge_d  = '0;
        end
      end
      StRun: begin
        div_d  = div_wrap ? '0 : div_q + 1'b1;
        seen_d = seen_nxt;
        if (div_wrap) tclk_d = !tclk_q;
        if (rise) edge_d = edge_inc;
        // Completion is checked first so a coincident timeout still reports pass.
        if (seen_nxt == {N_TESTS{1'b1}}) begin
          state_d = StPass;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          tclk_d  = 1'b0;
        end else if (rise && (edge_inc == CW'(TIMEOUT))) begin
          state_d = StFail;
          done_d  = 1'b1;
          to_d    = 1'b1;
          tclk_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    run_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      tclk_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      seen_q  <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tclk_q  <= tclk_d;
      run_q   <= run_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      seen_q  <= seen_d;
      edge_q  <= edge_d;
    end
  end

  assign test_clk   = tclk_q;
  assign test_run   = run_q;
  assign done       = done_q;
  assign all_passed = pass_q;
  assign timed_out  = to_q;
  assign seen       = seen_q;
  assign edge_count = edge_q;

endmodule

// File: tb/tb_t_chg_sequencer.sv
// Scoreboard bench for t_chg_sequencer: runs are planned, their outcome predicted by a
// cycle-indexed model of the edge schedule, and checked by a monitor when done rises.
module tb_t_chg_sequencer;

  localparam int unsigned N       = 4;
  localparam int unsigned DIV     = 4;
  localparam int unsigned TIMEOUT = 5;
  localparam int unsigned CW      = 16;

  logic          clk, reset, start;
  logic [N-1:0]  passed_in;
  logic          test_clk, test_run, done, all_passed, timed_out;
  logic [N-1:0]  seen;
  logic [CW-1:0] edge_count;

  t_chg_sequencer #(.N_TESTS(N), .DIV(DIV), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .passed_in  (passed_in),
    .test_clk   (test_clk),
    .test_run   (test_run),
    .done       (done),
    .all_passed (all_passed),
    .timed_out  (timed_out),
    .seen       (seen),
    .edge_count (edge_count)
  );

  typedef struct {
    int            cyc;
    logic          ap;
    logic          to;
    logic [N-1:0]  seen;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] plan_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [N-1:0] last_seen = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] plan_at(input int k);
    if (k <= plan_q.size()) return plan_q[k-1];
    return plan_q[plan_q.size()-1];
  endfunction

  // Cycle k after entry samples plan_at(k); rising edges land at k = DIV, 3*DIV, ...
  function automatic exp_t model(input int entry);
    exp_t         e;
    logic [N-1:0] s = '0;
    int           edges = 0;
    e.cyc = 0; e.ap = 0; e.to = 0; e.seen = '0; e.ec = '0;
    for (int k = 1; k <= 2 * DIV * TIMEOUT + 4; k++) begin
      s |= plan_at(k);
      if (k % (2 * DIV) == DIV) edges++;
      if (s == {N{1'b1}} || edges == TIMEOUT) begin
        e.cyc  = entry + k;
        e.ap   = (s == {N{1'b1}});
        e.to   = (s != {N{1'b1}});
        e.seen = s;
        e.ec   = CW'(edges);
        return e;
      end
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    logic done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_prev = 1'b0;
      end else begin
        if (done && !done_prev) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("all_passed", all_passed, e.ap);
            check("timed_out", timed_out, e.to);
            check("final_seen", seen, e.seen);
            check("final_edge_count", edge_count, e.ec);
            check("final_test_clk", test_clk, 0);
            check("final_test_run", test_run, 0);
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic run_plan(input bit rand_start);
    exp_t         e;
    int           entry, kexp;
    logic [N-1:0] s = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    entry = cyc;
    check("entry_seen_clear", seen, 0);
    check("entry_edge_clear", edge_count, 0);
    check("entry_flags_clear", {done, all_passed, timed_out}, 0);
    check("entry_test_run", test_run, 1);
    e = model(entry);
    kexp = e.cyc - entry;
    sb_q.push_back(e);
    for (int k = 1; k <= kexp; k++) begin
      passed_in = plan_at(k);
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      s |= plan_at(k);
      tick();
      if (k < kexp) begin
        check("run_test_clk", test_clk, (k / DIV) % 2);
        check("run_edge_count", edge_count, (k + DIV) / (2 * DIV));
        check("run_seen", seen, s);
        check("run_done_low", done, 0);
      end
    end
    start = 1'b0;
    passed_in = N'($urandom);
    tick();
    tick();
    check("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
    last_seen = e.seen;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      passed_in = N'($urandom);
      tick();
      check("idle_test_clk", test_clk, 0);
      check("idle_test_run", test_run, 0);
      check("idle_seen_frozen", seen, last_seen);
    end
  endtask

  initial begin : stimulus
    logic [N-1:0] p;
    int           len;
    reset = 1'b1;
    start = 1'b0;
    passed_in = '0;
    repeat (3) tick();
    check("reset_outputs", {test_clk, test_run, done, all_passed, timed_out}, 0);
    check("reset_seen", seen, 0);
    check("reset_edge_count", edge_count, 0);
    reset = 1'b0;
    idle_cycles(5);

    // Bits 0,2 then 1,3 later: pass at cycle 10.
    plan_q.delete();
    repeat (9) plan_q.push_back(4'b0101);
    plan_q.push_back(4'b1111);
    run_plan(0);
    idle_cycles(2);

    // Single flag held: runs long enough to see the divider schedule, then times out.
    plan_q.delete();
    plan_q.push_back(4'b0001);
    run_plan(0);

    // Three of four flags: timeout at the 5th rising edge.
    plan_q.delete();
    plan_q.push_back(4'b0111);
    run_plan(0);

    // Last flag arrives on the 5th rising edge: pass wins.
    plan_q.delete();
    repeat (2 * DIV * TIMEOUT - DIV - 1) plan_q.push_back(4'b0111);
    plan_q.push_back(4'b1111);
    run_plan(0);

    // Reset in the middle of a run aborts without a report.
    start = 1'b1;
    tick();
    start = 1'b0;
    passed_in = 4'b0011;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_reset_outputs", {test_clk, test_run, done, all_passed, timed_out}, 0);
    check("midrun_reset_seen", seen, 0);
    check("midrun_reset_edge", edge_count, 0);
    last_seen = '0;
    idle_cycles(3);

    // Fail, then a fresh run straight from the terminal state.
    plan_q.delete();
    plan_q.push_back(4'b1000);
    run_plan(0);
    plan_q.delete();
    plan_q.push_back(4'b0110);
    plan_q.push_back(4'b1111);
    run_plan(0);

    for (int r = 0; r < 25; r++) begin
      plan_q.delete();
      p = '0;
      len = $urandom_range(1, 45);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) p |= N'(1 << $urandom_range(0, N - 1));
        plan_q.push_back(p);
      end
      idle_cycles($urandom_range(0, 4));
      run_plan(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
